// File: rtl/mul_issue_ctrl_pkg.sv
// Shared opcode encodings for the EXE-stage multiplier and its issue controller.
// Ops are one-hot; MUL_OP_NONE marks a bubble and makes the multiplier produce 0.
// mul_op_is_onehot() screens EXE opcodes before they reach the datapath.
package mul_issue_ctrl_pkg;

    localparam int MUL_OP_W = 3;

    localparam logic [MUL_OP_W-1:0] MUL_OP_NONE   = 3'b000;
    localparam logic [MUL_OP_W-1:0] MUL_OP_MULW   = 3'b001;
    localparam logic [MUL_OP_W-1:0] MUL_OP_MULHW  = 3'b010;
    localparam logic [MUL_OP_W-1:0] MUL_OP_MULHWU = 3'b100;

    function automatic logic mul_op_is_onehot(input logic [MUL_OP_W-1:0] op);
        return (op == MUL_OP_MULW) || (op == MUL_OP_MULHW) || (op == MUL_OP_MULHWU);
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_multiplier.sv
// Pipelined 32x32 multiplier datapath: mul.w (low word), mulh.w / mulh.wu (high word).
// Latency: one register stage, result valid the cycle after the op is presented.
// Backpressure: none; it cannot stall, the caller must capture every result.
// Ports: clk/reset (sync, active-high), op (one-hot or NONE), src1/src2 operands, res registered result.
module mul_issue_ctrl_multiplier
    import mul_issue_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [MUL_OP_W-1:0] op,
    input  logic [31:0]         src1,
    input  logic [31:0]         src2,
    output logic [31:0]         res
);

    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] product;
    logic [31:0] res_d;
    logic [31:0] res_q;

    // Extending both operands to 64 bits (sign-extended only for mulh.w) lets one
    // modulo-2^64 unsigned multiply serve signed and unsigned high-word ops alike.
    always_comb begin
        op_a    = {{32{(op == MUL_OP_MULHW) & src1[31]}}, src1};
        op_b    = {{32{(op == MUL_OP_MULHW) & src2[31]}}, src2};
        product = op_a * op_b;
        res_d   = 32'h0;
        case (op)
            MUL_OP_MULW:                 res_d = product[31:0];
            MUL_OP_MULHW, MUL_OP_MULHWU: res_d = product[63:32];
            default:                     res_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q <= 32'h0;
        end else begin
            res_q <= res_d;
        end
    end

    assign res = res_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller for the EXE-stage multiplier with a one-entry hold buffer toward MEM.
// Latency: op accepted in cycle t is presented (out_valid) in cycle t+1; 1 op/cycle sustained.
// Backpressure: MEM stall parks the result in the hold buffer and drops in_ready until it drains.
// Ports: clk/reset (sync, active-high), flush, in_* valid/ready op from EXE, out_* valid/ready result
//        to MEM, perf_issue_cnt/perf_stall_cnt counters.
// Build option: define MUL_CTRL_PERF_EN to implement the perf counters; otherwise they read 0.
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MUL_OP_W-1:0] in_op,
    input  logic [31:0]         in_src1,
    input  logic [31:0]         in_src2,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_res,
    output logic [TAG_W-1:0]    out_tag,
    output logic [31:0]         perf_issue_cnt,
    output logic [31:0]         perf_stall_cnt
);

    logic                fire_in;
    logic [MUL_OP_W-1:0] mul_op;
    logic [31:0]         mul_res;

    logic                s1_valid_d, s1_valid_q;
    logic [TAG_W-1:0]    s1_tag_d,   s1_tag_q;
    logic                hold_valid_d, hold_valid_q;
    logic [31:0]         hold_res_d,   hold_res_q;
    logic [TAG_W-1:0]    hold_tag_d,   hold_tag_q;

    // A result sitting at the multiplier output that MEM refuses this cycle will be
    // copied into hold, so no new op may enter behind it.
    assign in_ready = ~hold_valid_q & ~(s1_valid_q & ~out_ready);
    assign fire_in  = in_valid & in_ready & ~flush;

    // Bubbles and malformed opcodes both drive NONE so the multiplier yields 0.
    assign mul_op = (fire_in && mul_op_is_onehot(in_op)) ? in_op : MUL_OP_NONE;

    mul_issue_ctrl_multiplier u_multiplier (
        .clk   (clk),
        .reset (reset),
        .op    (mul_op),
        .src1  (in_src1),
        .src2  (in_src2),
        .res   (mul_res)
    );

    // s1_valid and hold_valid are mutually exclusive, hold wins the mux.
    assign out_valid = s1_valid_q | hold_valid_q;
    assign out_res   = hold_valid_q ? hold_res_q : (s1_valid_q ? mul_res  : 32'h0);
    assign out_tag   = hold_valid_q ? hold_tag_q : (s1_valid_q ? s1_tag_q : '0);

    always_comb begin
        s1_valid_d   = fire_in;
        s1_tag_d     = fire_in ? in_tag : s1_tag_q;
        hold_valid_d = hold_valid_q;
        hold_res_d   = hold_res_q;
        hold_tag_d   = hold_tag_q;
        if (s1_valid_q && !out_ready) begin
            hold_valid_d = 1'b1;
            hold_res_d   = mul_res;
            hold_tag_d   = s1_tag_q;
        end else if (hold_valid_q && out_ready) begin
            hold_valid_d = 1'b0;
        end
        // fire_in is already masked by flush, so s1 empties on its own.
        if (flush) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_tag_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_res_q   <= 32'h0;
            hold_tag_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_tag_q     <= s1_tag_d;
            hold_valid_q <= hold_valid_d;
            hold_res_q   <= hold_res_d;
            hold_tag_q   <= hold_tag_d;
        end
    end

`ifdef MUL_CTRL_PERF_EN
    logic        stall;
    logic [31:0] perf_issue_d, perf_issue_q;
    logic [31:0] perf_stall_d, perf_stall_q;

    assign stall = in_valid & ~in_ready & ~flush;

    // Free-running 32-bit counters, wrap naturally.
    always_comb begin
        perf_issue_d = perf_issue_q + 32'(fire_in);
        perf_stall_d = perf_stall_q + 32'(stall);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issue_q <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_issue_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule
